// File: rtl/xeng_vacc.sv
// Long-term vector accumulator for X-engine dumps: read-modify-write of per-baseline
// partial sums held in block RAM, emitting each finished integration with sync/timestamp.
module xeng_vacc #(
    parameter int N_ANTS        = 32,
    parameter int VEC_LEN       = N_ANTS * (N_ANTS / 2 + 1),
    parameter int W_IN          = 18,
    parameter int W_OUT         = 32,
    parameter int BRAM_LATENCY  = 2,
    parameter int ACC_LEN_WIDTH = 16,
    parameter int MCNT_WIDTH    = 48,
    localparam int AW           = $clog2(VEC_LEN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sync_in,
    input  logic [8*W_IN-1:0]        din,
    input  logic                     vld,
    input  logic [MCNT_WIDTH-1:0]    mcnt,
    input  logic [ACC_LEN_WIDTH-1:0] acc_len,
    output logic [8*W_OUT-1:0]       dout,
    output logic                     vld_out,
    output logic                     sync_out,
    output logic [AW-1:0]            bl_idx,
    output logic [MCNT_WIDTH-1:0]    mcnt_out
);
    localparam int L = BRAM_LATENCY;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACC = 1'b1} state_t;

    function automatic logic [8*W_OUT-1:0] f_sext(input logic [8*W_IN-1:0] d);
        logic [8*W_OUT-1:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k*W_OUT +: W_OUT] = {{(W_OUT-W_IN){d[k*W_IN+W_IN-1]}}, d[k*W_IN +: W_IN]};
        end
        return r;
    endfunction

    logic [1:0]               r_rst_sync;
    logic                     w_rst_n;
    state_t                   r_state, w_state_nxt;
    logic                     w_accept;
    logic [AW-1:0]            r_addr;
    logic [ACC_LEN_WIDTH-1:0] r_dump, r_acc_len;
    logic                     w_dump_last;
    logic [MCNT_WIDTH-1:0]    r_mcnt_hold;
    logic                     r_armed;
    logic                     r_pv    [0:L+1];
    logic [AW-1:0]            r_pa    [0:L+1];
    logic                     r_plast [0:L+1];
    logic                     r_pfirst[0:L];
    logic [8*W_OUT-1:0]       r_pdin  [0:L];
    logic [8*W_OUT-1:0]       r_rd    [1:L];
    logic [8*W_OUT-1:0]       r_new, w_sum;
    logic [8*W_OUT-1:0]       r_mem   [VEC_LEN];

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // State register.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = sync_in ? ST_ACC : ST_IDLE;
            ST_ACC:  w_state_nxt = ST_ACC;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Word acceptance; a word arriving with sync_in belongs to no integration.
    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            ST_ACC:  w_accept = vld && !sync_in;
            default: w_accept = 1'b0;
        endcase
    end

    assign w_dump_last = (r_dump == r_acc_len - ACC_LEN_WIDTH'(1));

    // Address / dump counters, integration length and timestamp capture.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_acc_len   <= ACC_LEN_WIDTH'(1);
            r_addr      <= '0;
            r_dump      <= '0;
            r_mcnt_hold <= '0;
        end else if (sync_in) begin
            r_acc_len <= (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
            r_addr    <= '0;
            r_dump    <= '0;
        end else if (w_accept) begin
            if (r_addr == AW'(VEC_LEN - 1)) begin
                r_addr <= '0;
                r_dump <= w_dump_last ? '0 : r_dump + ACC_LEN_WIDTH'(1);
            end else begin
                r_addr <= r_addr + AW'(1);
            end
            if (r_addr == '0 && r_dump == '0) r_mcnt_hold <= mcnt;
        end
    end

    // Tag/data pipeline, aligned with the memory read latency; sync flushes it.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int k = 0; k <= L + 1; k++) begin
                r_pv[k]    <= 1'b0;
                r_pa[k]    <= '0;
                r_plast[k] <= 1'b0;
            end
            for (int k = 0; k <= L; k++) begin
                r_pfirst[k] <= 1'b0;
                r_pdin[k]   <= '0;
            end
            r_new <= '0;
        end else begin
            r_pv[0]     <= w_accept;
            r_pa[0]     <= r_addr;
            r_plast[0]  <= w_dump_last;
            r_pfirst[0] <= (r_dump == '0);
            r_pdin[0]   <= f_sext(din);
            for (int k = 1; k <= L + 1; k++) begin
                r_pv[k]    <= r_pv[k-1] && !sync_in;
                r_pa[k]    <= r_pa[k-1];
                r_plast[k] <= r_plast[k-1];
            end
            for (int k = 1; k <= L; k++) begin
                r_pfirst[k] <= r_pfirst[k-1];
                r_pdin[k]   <= r_pdin[k-1];
            end
            r_new <= w_sum;
        end
    end

    // Accumulation memory: no forwarding, same-address accesses are VEC_LEN words apart.
    always_ff @(posedge clk) begin
        if (r_pv[L+1] && !sync_in) r_mem[r_pa[L+1]] <= r_new;
        r_rd[1] <= r_mem[r_pa[0]];
        for (int k = 2; k <= L; k++) r_rd[k] <= r_rd[k-1];
    end

    // Per-component add, modulo 2^W_OUT; first dump discards stale memory contents.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 8; k++) begin
            if (r_pfirst[L]) w_sum[k*W_OUT +: W_OUT] = r_pdin[L][k*W_OUT +: W_OUT];
            else             w_sum[k*W_OUT +: W_OUT] = r_rd[L][k*W_OUT +: W_OUT] + r_pdin[L][k*W_OUT +: W_OUT];
        end
    end

    // Output register: emits only words of the final dump of an integration.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            dout     <= '0;
            vld_out  <= 1'b0;
            sync_out <= 1'b0;
            bl_idx   <= '0;
            mcnt_out <= '0;
            r_armed  <= 1'b0;
        end else if (sync_in) begin
            vld_out  <= 1'b0;
            sync_out <= 1'b0;
            r_armed  <= 1'b1;
        end else if (r_pv[L+1] && r_plast[L+1]) begin
            dout     <= r_new;
            vld_out  <= 1'b1;
            sync_out <= r_armed;
            bl_idx   <= r_pa[L+1];
            r_armed  <= 1'b0;
            if (r_pa[L+1] == '0) mcnt_out <= r_mcnt_hold;
        end else begin
            vld_out  <= 1'b0;
            sync_out <= 1'b0;
        end
    end
endmodule
